// File: rtl/count_ctrl.sv
// count_ctrl: command-driven up counter with one-shot and periodic modes
module count_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;
  localparam logic [1:0] OP_START = 2'b00, OP_STOP = 2'b01, OP_PAUSE = 2'b10, OP_RESUME = 2'b11;
  state_t state, state_n;
  logic [WIDTH-1:0] count_n, limit_q, limit_n;
  logic periodic_q, periodic_n, tick_n, acc, at_limit;
  assign cmd_ready = reset & (state != LOAD);
  assign busy = (state == LOAD) | (state == RUN) | (state == PAUSE);
  assign done = state == DONE;
  assign acc = cmd_valid & cmd_ready;
  assign at_limit = count == limit_q;
  // next state: START/STOP override everything, then per-state counting rules
  always_comb begin
    state_n = state;
    count_n = count;
    limit_n = limit_q;
    periodic_n = periodic_q;
    tick_n = 1'b0;
    if (acc && cmd_op == OP_START) begin
      state_n = LOAD;
      count_n = '0;
      limit_n = cfg_limit;
      periodic_n = cfg_periodic;
    end else if (acc && cmd_op == OP_STOP) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        LOAD: begin
          state_n = RUN;
          count_n = '0;
        end
        RUN: begin
          if (at_limit && periodic_q) begin
            count_n = '0;
            tick_n = 1'b1;
            state_n = (acc && cmd_op == OP_PAUSE) ? PAUSE : RUN;
          end else if (at_limit) begin
            state_n = DONE;
          end else if (acc && cmd_op == OP_PAUSE) begin
            state_n = PAUSE;
          end else begin
            count_n = count + 1'b1;
          end
        end
        PAUSE: state_n = (acc && cmd_op == OP_RESUME) ? RUN : PAUSE;
        DONE: state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      limit_q <= '0;
      periodic_q <= 1'b0;
      tick <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      limit_q <= limit_n;
      periodic_q <= periodic_n;
      tick <= tick_n;
    end
  end
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed and randomized checks of count_ctrl against a behavioural model
module tb_count_ctrl;
  logic clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, cfg_periodic = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cfg_limit = 8'd0;
  logic cmd_ready, busy, tick, done;
  logic [7:0] count;
  int n_chk = 0, n_fail = 0;
  int m_count = 0, m_limit = 0;
  bit m_per = 0, m_loading = 0, m_running = 0, m_paused = 0, m_finishing = 0, m_tick = 0;
  int exp_c[10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  int exp_t[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
  count_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .cfg_limit(cfg_limit), .cfg_periodic(cfg_periodic), .count(count), .busy(busy),
    .tick(tick), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model stepped on each rising edge, compared just after it
  always @(posedge clk) begin
    bit acc;
    acc = cmd_valid && !m_loading;
    m_tick = 0;
    if (!reset) begin
      m_count = 0; m_limit = 0; m_per = 0;
      m_loading = 0; m_running = 0; m_paused = 0; m_finishing = 0;
    end else if (acc && cmd_op == 2'b00) begin
      m_limit = int'(cfg_limit); m_per = cfg_periodic; m_count = 0;
      m_loading = 1; m_running = 0; m_paused = 0; m_finishing = 0;
    end else if (acc && cmd_op == 2'b01) begin
      m_count = 0; m_loading = 0; m_running = 0; m_paused = 0; m_finishing = 0;
    end else if (m_loading) begin
      m_loading = 0; m_running = 1; m_count = 0;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (m_running) begin
      if (m_count == m_limit && m_per) begin
        m_count = 0; m_tick = 1;
        if (acc && cmd_op == 2'b10) begin m_running = 0; m_paused = 1; end
      end else if (m_count == m_limit) begin
        m_running = 0; m_finishing = 1;
      end else if (acc && cmd_op == 2'b10) begin
        m_running = 0; m_paused = 1;
      end else begin
        m_count = m_count + 1;
      end
    end else if (m_paused && acc && cmd_op == 2'b11) begin
      m_paused = 0; m_running = 1;
    end
    #1;
    chk("model count", int'(count), m_count);
    chk("model tick", int'(tick), int'(m_tick));
    chk("model done", int'(done), int'(m_finishing));
    chk("model busy", int'(busy), int'(m_loading | m_running | m_paused));
    chk("model cmd_ready", int'(cmd_ready), int'(reset && !m_loading));
  end
  task automatic issue(input logic [1:0] op, input int lim, input bit per);
    cmd_valid = 1'b1; cmd_op = op; cfg_limit = lim[7:0]; cfg_periodic = per;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset count", int'(count), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset cmd_ready", int'(cmd_ready), 0);
    reset = 1'b1;
    #1 chk("release cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    issue(2'b00, 3, 1);
    for (int i = 0; i < 10; i++) begin
      chk("periodic count", int'(count), exp_c[i]);
      chk("periodic tick", int'(tick), exp_t[i]);
      chk("periodic busy", int'(busy), 1);
      @(negedge clk);
    end
    issue(2'b00, 5, 0);
    repeat (6) @(negedge clk);
    chk("oneshot last", int'(count), 5);
    @(negedge clk);
    chk("oneshot done", int'(done), 1);
    chk("oneshot done count", int'(count), 5);
    @(negedge clk);
    chk("oneshot idle done", int'(done), 0);
    chk("oneshot idle busy", int'(busy), 0);
    chk("oneshot idle count", int'(count), 5);
    issue(2'b00, 10, 1);
    repeat (5) @(negedge clk);
    chk("pre-pause count", int'(count), 4);
    issue(2'b10, 0, 0);
    chk("pause count 1", int'(count), 4);
    repeat (2) @(negedge clk);
    chk("pause count 3", int'(count), 4);
    chk("pause busy", int'(busy), 1);
    issue(2'b11, 0, 0);
    chk("resume count", int'(count), 4);
    @(negedge clk);
    chk("resume count+1", int'(count), 5);
    @(negedge clk);
    chk("resume count+2", int'(count), 6);
    issue(2'b00, 2, 1);
    repeat (3) @(negedge clk);
    chk("stop-at-limit pre", int'(count), 2);
    issue(2'b01, 0, 0);
    chk("stop-at-limit count", int'(count), 0);
    chk("stop-at-limit tick", int'(tick), 0);
    chk("stop-at-limit busy", int'(busy), 0);
    issue(2'b00, 0, 1);
    @(negedge clk);
    chk("limit0 first run tick", int'(tick), 0);
    @(negedge clk);
    chk("limit0 tick a", int'(tick), 1);
    @(negedge clk);
    chk("limit0 tick b", int'(tick), 1);
    issue(2'b00, 20, 1);
    repeat (8) @(negedge clk);
    chk("pre-reset count", int'(count), 7);
    #2 reset = 1'b0;
    #1;
    chk("async reset count", int'(count), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset tick", int'(tick), 0);
    chk("async reset done", int'(done), 0);
    chk("async reset cmd_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("post-reset cmd_ready", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    chk("post-reset count", int'(count), 0);
    chk("post-reset busy", int'(busy), 0);
    cmd_valid = 1'b1; cmd_op = 2'b00; cfg_limit = 8'd9; cfg_periodic = 1'b1;
    @(negedge clk);
    cmd_op = 2'b01;
    chk("load cmd_ready", int'(cmd_ready), 0);
    @(negedge clk);
    chk("after load cmd_ready", int'(cmd_ready), 1);
    chk("after load busy", int'(busy), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("load-stop count", int'(count), 0);
    chk("load-stop busy", int'(busy), 0);
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_op = 2'($urandom_range(0, 3));
      cfg_limit = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      cfg_periodic = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
